// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: ID-stage branch compare with hazard stalls, flush control and saturating perf counters
module branch_resolve_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  ID_Branch,
  input  logic [4:0]  ID_Ra,
  input  logic [4:0]  ID_Rb,
  input  logic [31:0] busA,
  input  logic [31:0] busB,
  input  logic [31:0] Mem_ALUout,
  input  logic        BranchForwardA,
  input  logic        BranchForwardB,
  input  logic [4:0]  Ex_Rw,
  input  logic [4:0]  Mem_Rw,
  input  logic        Ex_RegWr,
  input  logic        Ex_MemtoReg,
  input  logic        Mem_RegWr,
  input  logic        Mem_MemtoReg,
  input  logic [31:0] ID_PCplus4,
  input  logic [15:0] ID_Imm16,
  output logic        Stall,
  output logic        PCSrc,
  output logic        IF_Flush,
  output logic [31:0] BranchTarget,
  output logic [15:0] BranchCnt,
  output logic [15:0] TakenCnt,
  output logic [15:0] StallCnt
);
  typedef enum logic {IDLE, HOLD1} state_t;
  state_t r_state, w_next;
  logic [31:0] w_op_a, w_op_b;
  logic [15:0] r_branch_cnt, r_taken_cnt, r_stall_cnt;
  logic w_valid, w_beq, w_bne, w_ex_match, w_mem_match;
  logic w_hz_ex_load, w_hz_ex_alu, w_hz_mem_load, w_hazard, w_resolve, w_taken;
  assign w_op_a = BranchForwardA ? Mem_ALUout : busA;
  assign w_op_b = BranchForwardB ? Mem_ALUout : busB;
  assign w_beq = ID_Branch == 2'b01;
  assign w_bne = ID_Branch == 2'b10;
  assign w_valid = w_beq | w_bne;
  assign w_ex_match = w_valid && Ex_Rw != 5'd0 && (Ex_Rw == ID_Ra || Ex_Rw == ID_Rb);
  assign w_mem_match = w_valid && Mem_Rw != 5'd0 && (Mem_Rw == ID_Ra || Mem_Rw == ID_Rb);
  assign w_hz_ex_load = w_ex_match & Ex_RegWr & Ex_MemtoReg;
  assign w_hz_ex_alu = w_ex_match & Ex_RegWr & ~Ex_MemtoReg;
  assign w_hz_mem_load = w_mem_match & Mem_RegWr & Mem_MemtoReg;
  assign w_hazard = w_hz_ex_load | w_hz_ex_alu | w_hz_mem_load;
  always_comb begin
    w_next = (r_state == IDLE && w_hz_ex_load) ? HOLD1 : IDLE;
    Stall = rst_n & ((r_state == HOLD1) | w_hazard);
    w_resolve = rst_n & (r_state == IDLE) & w_valid & ~w_hazard;
    w_taken = w_resolve & ((w_beq & (w_op_a == w_op_b)) | (w_bne & (w_op_a != w_op_b)));
  end
  assign PCSrc = w_taken;
  assign IF_Flush = w_taken;
  assign BranchTarget = ID_PCplus4 + {{14{ID_Imm16[15]}}, ID_Imm16, 2'b00};
  assign BranchCnt = r_branch_cnt;
  assign TakenCnt = r_taken_cnt;
  assign StallCnt = r_stall_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_branch_cnt <= 16'd0;
      r_taken_cnt <= 16'd0;
      r_stall_cnt <= 16'd0;
    end else begin
      r_state <= w_next;
      if (w_resolve && r_branch_cnt != 16'hFFFF) r_branch_cnt <= r_branch_cnt + 16'd1;
      if (w_taken && r_taken_cnt != 16'hFFFF) r_taken_cnt <= r_taken_cnt + 16'd1;
      if (Stall && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: table-driven and sequence checks for branch_resolve_unit
module tb_branch_resolve_unit;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [1:0] ID_Branch;
  logic [4:0] ID_Ra, ID_Rb, Ex_Rw, Mem_Rw;
  logic [31:0] busA, busB, Mem_ALUout, ID_PCplus4, BranchTarget;
  logic BranchForwardA, BranchForwardB, Ex_RegWr, Ex_MemtoReg, Mem_RegWr, Mem_MemtoReg;
  logic [15:0] ID_Imm16, BranchCnt, TakenCnt, StallCnt;
  logic Stall, PCSrc, IF_Flush;
  int total = 0, bad = 0;
  int exp_br = 0, exp_tk = 0, exp_st = 0;
  typedef struct {
    logic [1:0] br; logic [4:0] ra, rb; logic [31:0] a, b, mem; logic fa, fb;
    logic [4:0] exrw; logic exw, exm; logic [4:0] mrw; logic mw, mm;
    logic [31:0] pc; logic [15:0] imm;
    logic e_stall, e_res, e_take; logic [31:0] e_tgt;
  } vec_t;
  vec_t v[15];
  branch_resolve_unit dut (
    .clk(clk), .rst_n(rst_n), .ID_Branch(ID_Branch), .ID_Ra(ID_Ra), .ID_Rb(ID_Rb),
    .busA(busA), .busB(busB), .Mem_ALUout(Mem_ALUout),
    .BranchForwardA(BranchForwardA), .BranchForwardB(BranchForwardB),
    .Ex_Rw(Ex_Rw), .Mem_Rw(Mem_Rw), .Ex_RegWr(Ex_RegWr), .Ex_MemtoReg(Ex_MemtoReg),
    .Mem_RegWr(Mem_RegWr), .Mem_MemtoReg(Mem_MemtoReg),
    .ID_PCplus4(ID_PCplus4), .ID_Imm16(ID_Imm16),
    .Stall(Stall), .PCSrc(PCSrc), .IF_Flush(IF_Flush), .BranchTarget(BranchTarget),
    .BranchCnt(BranchCnt), .TakenCnt(TakenCnt), .StallCnt(StallCnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  task automatic idle_in();
    ID_Branch = 2'b00; ID_Ra = 5'd0; ID_Rb = 5'd0; busA = 32'd0; busB = 32'd0; Mem_ALUout = 32'd0;
    BranchForwardA = 1'b0; BranchForwardB = 1'b0; Ex_Rw = 5'd0; Ex_RegWr = 1'b0; Ex_MemtoReg = 1'b0;
    Mem_Rw = 5'd0; Mem_RegWr = 1'b0; Mem_MemtoReg = 1'b0; ID_PCplus4 = 32'd0; ID_Imm16 = 16'd0;
  endtask
  task automatic apply(input vec_t x);
    ID_Branch = x.br; ID_Ra = x.ra; ID_Rb = x.rb; busA = x.a; busB = x.b; Mem_ALUout = x.mem;
    BranchForwardA = x.fa; BranchForwardB = x.fb; Ex_Rw = x.exrw; Ex_RegWr = x.exw; Ex_MemtoReg = x.exm;
    Mem_Rw = x.mrw; Mem_RegWr = x.mw; Mem_MemtoReg = x.mm; ID_PCplus4 = x.pc; ID_Imm16 = x.imm;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_in();
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic chk_cnt(input string tag, input int br, input int tk, input int st);
    chk({tag, " BranchCnt"}, {16'd0, BranchCnt}, br);
    chk({tag, " TakenCnt"}, {16'd0, TakenCnt}, tk);
    chk({tag, " StallCnt"}, {16'd0, StallCnt}, st);
  endtask
  task automatic chk_out(input string tag, input logic st, input logic tk);
    chk({tag, " Stall"}, {31'd0, Stall}, {31'd0, st});
    chk({tag, " PCSrc"}, {31'd0, PCSrc}, {31'd0, tk});
    chk({tag, " IF_Flush"}, {31'd0, IF_Flush}, {31'd0, tk});
  endtask
  initial begin
    v[0]  = '{2'b01, 5'd1, 5'd2, 32'd5, 32'd5, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h100, 16'hFFFE, 1'b0, 1'b1, 1'b1, 32'hF8};
    v[1]  = '{2'b10, 5'd1, 5'd2, 32'd5, 32'd5, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h200, 16'h0010, 1'b0, 1'b1, 1'b0, 32'h240};
    v[2]  = '{2'b10, 5'd1, 5'd2, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'hFFFFFFFC, 16'h0001, 1'b0, 1'b1, 1'b1, 32'h0};
    v[3]  = '{2'b01, 5'd1, 5'd2, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 16'h8000, 1'b0, 1'b1, 1'b0, 32'hFFFE0000};
    v[4]  = '{2'b11, 5'd1, 5'd2, 32'd5, 32'd5, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h40, 16'h0000, 1'b0, 1'b0, 1'b0, 32'h40};
    v[5]  = '{2'b00, 5'd1, 5'd2, 32'd5, 32'd5, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 16'h0000, 1'b0, 1'b0, 1'b0, 32'h0};
    v[6]  = '{2'b01, 5'd0, 5'd1, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 16'h0000, 1'b0, 1'b1, 1'b1, 32'h0};
    v[7]  = '{2'b01, 5'd3, 5'd1, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 16'h0000, 1'b1, 1'b0, 1'b0, 32'h0};
    v[8]  = '{2'b01, 5'd6, 5'd1, 32'd0, 32'd9, 32'd9, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b1, 32'h0, 16'h0000, 1'b1, 1'b0, 1'b0, 32'h0};
    v[9]  = '{2'b01, 5'd6, 5'd1, 32'd0, 32'd9, 32'd9, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0, 32'h0, 16'h0000, 1'b0, 1'b1, 1'b1, 32'h0};
    v[10] = '{2'b10, 5'd3, 5'd2, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0, 5'd3, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 32'h0, 16'h0000, 1'b0, 1'b1, 1'b0, 32'h0};
    v[11] = '{2'b01, 5'd1, 5'd2, 32'd4, 32'd0, 32'd4, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 16'h0000, 1'b0, 1'b1, 1'b1, 32'h0};
    v[12] = '{2'b11, 5'd3, 5'd2, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 16'h0000, 1'b0, 1'b0, 1'b0, 32'h0};
    v[13] = '{2'b10, 5'd1, 5'd7, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 16'h0000, 1'b1, 1'b0, 1'b0, 32'h0};
    v[14] = '{2'b01, 5'd1, 5'd2, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 16'h7FFF, 1'b0, 1'b1, 1'b0, 32'h1FFFC};
    idle_in();
    v[0].a = 32'd5;
    apply(v[0]);
    #1 chk_out("in_reset", 1'b0, 1'b0);
    do_reset();
    #1 chk_cnt("after_reset", 0, 0, 0);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      apply(v[i]);
      #1;
      chk_out($sformatf("vec%0d", i), v[i].e_stall, v[i].e_take);
      chk($sformatf("vec%0d BranchTarget", i), BranchTarget, v[i].e_tgt);
      exp_br += int'(v[i].e_res); exp_tk += int'(v[i].e_take); exp_st += int'(v[i].e_stall);
    end
    @(negedge clk);
    idle_in();
    #1 chk_cnt("table", exp_br, exp_tk, exp_st);
    do_reset();
    ID_Branch = 2'b10; ID_Ra = 5'd3; ID_Rb = 5'd2; Ex_Rw = 5'd3; Ex_RegWr = 1'b1; busB = 32'd7;
    #1 chk_out("exalu_stall", 1'b1, 1'b0);
    @(negedge clk);
    Ex_RegWr = 1'b0; Ex_Rw = 5'd0; BranchForwardA = 1'b1; Mem_ALUout = 32'd7;
    #1 chk_out("exalu_resolve", 1'b0, 1'b0);
    @(negedge clk);
    idle_in();
    #1 chk_cnt("exalu", 1, 0, 1);
    do_reset();
    ID_Branch = 2'b01; ID_Ra = 5'd1; ID_Rb = 5'd4; Ex_Rw = 5'd4; Ex_RegWr = 1'b1; Ex_MemtoReg = 1'b1; busA = 32'd8; busB = 32'd8;
    #1 chk_out("load_stall1", 1'b1, 1'b0);
    @(negedge clk);
    Ex_RegWr = 1'b0; Ex_MemtoReg = 1'b0; Ex_Rw = 5'd0;
    #1 chk_out("load_hold1", 1'b1, 1'b0);
    @(negedge clk);
    #1 chk_out("load_resolve", 1'b0, 1'b1);
    @(negedge clk);
    idle_in();
    #1 chk_cnt("load", 1, 1, 2);
    do_reset();
    ID_Branch = 2'b01; ID_Ra = 5'd5; Ex_Rw = 5'd5; Ex_RegWr = 1'b1; Ex_MemtoReg = 1'b1;
    @(negedge clk);
    #1 chk_out("pre_rst_hold1", 1'b1, 1'b0);
    rst_n = 1'b0;
    #1 chk_out("rst_mid_hold", 1'b0, 1'b0);
    chk_cnt("rst_mid_hold", 0, 0, 0);
    @(negedge clk);
    Ex_RegWr = 1'b0; busA = 32'd2; busB = 32'd2;
    rst_n = 1'b1;
    #1 chk_out("post_rst_idle", 1'b0, 1'b1);
    do_reset();
    ID_Branch = 2'b01; busA = 32'd1; busB = 32'd1;
    for (int i = 0; i < 65540; i++) @(negedge clk);
    idle_in();
    #1 chk_cnt("saturate", 32'hFFFF, 32'hFFFF, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 The module SHALL have exactly one clock and one reset; reset is asynchronous and active-low.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 ID_Branch  in  2  branch type in ID: 00 none, 01 beq, 10 bne, 11 treated as none.
REQ-005 ID_Ra, ID_Rb  in  5 each  ID source register numbers.
REQ-006 busA, busB  in  32 each  register-file read data.
REQ-007 Mem_ALUout  in  32  MEM-stage ALU result, forwarding source.
REQ-008 BranchForwardA, BranchForwardB  in  1 each  select Mem_ALUout instead of busA/busB.
REQ-009 Ex_Rw, Mem_Rw  in  5 each; Ex_RegWr, Ex_MemtoReg, Mem_RegWr, Mem_MemtoReg  in  1 each  producer info.
REQ-010 ID_PCplus4  in  32; ID_Imm16  in  16  branch base and offset.
REQ-011 Stall  out  1  freeze PC and IF/ID, insert bubble into ID/EX.
REQ-012 PCSrc  out  1  select BranchTarget as next PC.
REQ-013 IF_Flush  out  1  zero the IF/ID instruction on the next edge.
REQ-014 BranchTarget  out  32  ID_PCplus4 + (sign-extended ID_Imm16 << 2).
REQ-015 BranchCnt, TakenCnt, StallCnt  out  16 each  performance counters.

Function
REQ-016 opA SHALL be Mem_ALUout if BranchForwardA, else busA; opB likewise with BranchForwardB and busB.
REQ-017 The module SHALL define a source match as ID_Branch valid, producer register nonzero, and producer register equal to ID_Ra or ID_Rb.
REQ-018 hz_ex_load SHALL be asserted on an EX match with Ex_RegWr=1 and Ex_MemtoReg=1.
REQ-019 hz_ex_alu SHALL be asserted on an EX match with Ex_RegWr=1 and Ex_MemtoReg=0.
REQ-020 hz_mem_load SHALL be asserted on a MEM match with Mem_RegWr=1 and Mem_MemtoReg=1.
REQ-021 The FSM SHALL have two states, IDLE and HOLD1.
REQ-022 In IDLE with hz_ex_load, the module SHALL drive Stall=1 and go to HOLD1.
REQ-023 In IDLE with hz_ex_alu or hz_mem_load and no hz_ex_load, the module SHALL drive Stall=1 and stay in IDLE, re-evaluating the hazard next cycle.
REQ-024 In HOLD1, the module SHALL drive Stall=1 unconditionally, suppress resolution, and return to IDLE.
REQ-025 In IDLE with a valid branch and no hazard, the module SHALL resolve the branch: taken = (beq and opA==opB) or (bne and opA!=opB).
REQ-026 On a taken branch, PCSrc and IF_Flush SHALL be 1 in the resolving cycle (combinational); otherwise both SHALL be 0.
REQ-027 BranchTarget SHALL be combinational and always valid; 32-bit addition wraps modulo 2^32.
REQ-028 PCSrc and IF_Flush SHALL be 0 whenever Stall=1.
REQ-029 BranchCnt SHALL increment on each resolving cycle.
REQ-030 TakenCnt SHALL increment on each taken resolution.
REQ-031 StallCnt SHALL increment on each cycle with Stall=1.
REQ-032 All counters SHALL saturate at 16'hFFFF.
REQ-033 The load-use path (2 stalls) SHALL rely on a write-before-read register file for the WB-stage value.

Reset
REQ-034 Asserting rst_n=0 at any time, including mid-stall, SHALL immediately force the state to IDLE and all counters to 0.
REQ-035 While in reset, Stall, PCSrc and IF_Flush SHALL be 0.
REQ-036 After release, operation SHALL begin on the first rising edge with rst_n=1.

Verification
REQ-037 Scenario: beq, busA=busB=5, no hazards -> PCSrc=1, IF_Flush=1, Stall=0, ID_PCplus4=0x100, Imm16=0xFFFE -> BranchTarget=0xF8; BranchCnt=1, TakenCnt=1.
REQ-038 Scenario: bne, Ex_Rw=ID_Ra=3, Ex_RegWr=1, Ex_MemtoReg=0 -> Stall=1 for 1 cycle; next cycle (bubble in EX, BranchForwardA=1, Mem_ALUout=7, busB=7) -> not taken, PCSrc=0, StallCnt=1.
REQ-039 Scenario: beq, EX load to ID_Rb=4 -> Stall=1 for exactly 2 cycles (IDLE→HOLD1→IDLE), then resolves; StallCnt=2.
REQ-040 Scenario: MEM load matching ID_Ra, plus BranchForwardA=1 -> Stall=1 for 1 cycle; no resolution while stalled.
REQ-041 Scenario: Ex_Rw=0 with Ex_RegWr=1 matching ID_Ra=0 -> no stall; ID_Branch=11 -> no resolution, no count.
REQ-042 Scenario: rst_n pulsed low during HOLD1 -> Stall=0 immediately, counters 0, IDLE after release; TakenCnt preset to 0xFFFF plus a taken branch -> holds 0xFFFF.
